// File: rtl/grant_xfer_mux.sv
// Forwards the granted master's beats to the shared slave port through a 2-entry
// registered skid buffer, returning a one-cycle xfer_last pulse that closes the grant.
module grant_xfer_mux #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int SW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    gnt,
    input  logic [N-1:0]    m_valid,
    input  logic [N*DW-1:0] m_data,
    input  logic [N-1:0]    m_last,
    output logic [N-1:0]    m_ready,
    output logic            s_valid,
    output logic [DW-1:0]   s_data,
    output logic            s_last,
    output logic [SW-1:0]   s_src,
    input  logic            s_ready,
    output logic [N-1:0]    xfer_last,
    output logic            busy,
    output logic            err_timeout
);
    // Slave handshake: a beat moves when s_valid & s_ready; s_* hold while s_valid & !s_ready.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = SW + 1 + DW;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [EW-1:0]   ent0_q, ent0_d, ent1_q, ent1_d;
    logic [N-1:0]    xfer_last_q, xfer_last_d;
    logic            err_q, err_d;

    logic            gnt_onehot;
    logic [SW-1:0]   gnt_idx;
    logic            owner_valid, owner_last, accept, pop, can_push;
    logic [DW-1:0]   owner_data;
    logic [EW-1:0]   new_ent;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = SW'(i);
        end
    end

    assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - {{(N-1){1'b0}}, 1'b1})) == '0);
    assign owner_valid = m_valid[owner_q];
    assign owner_last  = m_last[owner_q];
    assign owner_data  = m_data[owner_q*DW +: DW];
    assign new_ent     = {owner_q, owner_last, owner_data};
    assign can_push    = (state_q == XFER) && (cnt_q != 2'd2);
    assign accept      = can_push && owner_valid;
    assign pop         = (cnt_q != 2'd0) && s_ready;

    always_comb begin
        m_ready = '0;
        if (can_push) m_ready[owner_q] = 1'b1;
    end

    // Entry 0 is always the head, so the slave outputs come straight from a register.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({accept, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = new_ent;
                else               ent1_d = new_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = new_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        idle_cnt_d  = idle_cnt_q;
        xfer_last_d = '0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_onehot) begin
                    owner_d    = gnt_idx;
                    idle_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (owner_valid)                        idle_cnt_d = '0;
                else if (idle_cnt_q != CW'(TIMEOUT))    idle_cnt_d = idle_cnt_q + 1'b1;
                if (accept && owner_last) begin
                    state_d              = DRAIN;
                    xfer_last_d[owner_q] = 1'b1;
                end else if (!owner_valid && idle_cnt_q == CW'(TIMEOUT - 1)) begin
                    // This idle cycle takes the counter to TIMEOUT: force termination.
                    state_d              = DRAIN;
                    err_d                = 1'b1;
                    xfer_last_d[owner_q] = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_d == 2'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            idle_cnt_q  <= '0;
            cnt_q       <= '0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            xfer_last_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            cnt_q       <= cnt_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            xfer_last_q <= xfer_last_d;
            err_q       <= err_d;
        end
    end

    assign s_valid               = (cnt_q != 2'd0);
    assign {s_src, s_last, s_data} = ent0_q;
    assign xfer_last             = xfer_last_q;
    assign busy                  = (state_q != IDLE);
    assign err_timeout           = err_q;

endmodule

// File: tb/tb_grant_xfer_mux.sv
// Randomized and directed bench for grant_xfer_mux against a queue-based
// transaction model of the ownership / buffering rules.
module tb_grant_xfer_mux;
    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int SW      = 2;
    localparam int EW      = SW + 1 + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    gnt;
    logic [N-1:0]    m_valid;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_last;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_last;
    logic [SW-1:0]   s_src;
    logic            s_ready;
    logic [N-1:0]    xfer_last;
    logic            busy;
    logic            err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = no owner, 1 = owner streaming, 2 = owner released, waiting to empty.
    logic [EW-1:0] exp_q[$];
    int            mode;
    int            owner;
    int            idle_run;
    logic [N-1:0]  exp_xl;
    logic          exp_err;

    grant_xfer_mux #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT), .SW(SW)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_src(s_src), .s_ready(s_ready), .xfer_last(xfer_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mode     = 0;
        owner    = 0;
        idle_run = 0;
        exp_xl   = '0;
        exp_err  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N-1:0]  exp_mr;
        logic [EW-1:0] head;
        exp_mr = '0;
        if (mode == 1 && exp_q.size() < 2) exp_mr[owner] = 1'b1;
        check("m_ready", 64'(m_ready), 64'(exp_mr));
        check("s_valid", 64'(s_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("s_data", 64'(s_data), 64'(head[DW-1:0]));
            check("s_last", 64'(s_last), 64'(head[DW]));
            check("s_src",  64'(s_src),  64'(head[EW-1 -: SW]));
        end
        check("xfer_last",   64'(xfer_last),   64'(exp_xl));
        check("busy",        64'(busy),        64'(mode != 0));
        check("err_timeout", 64'(err_timeout), 64'(exp_err));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit            pop, acc;
        logic [EW-1:0] beat;
        if (rst) begin
            model_reset();
            return;
        end
        pop  = (exp_q.size() > 0) && s_ready;
        acc  = (mode == 1) && m_valid[owner] && (exp_q.size() < 2);
        beat = {SW'(owner), m_last[owner], m_data[owner*DW +: DW]};
        exp_xl = '0;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(beat);
        case (mode)
            0: begin
                if ($countones(gnt) == 1) begin
                    for (int i = 0; i < N; i++) if (gnt[i]) owner = i;
                    idle_run = 0;
                    mode     = 1;
                end
            end
            1: begin
                if (m_valid[owner]) idle_run = 0;
                else                idle_run++;
                if (acc && m_last[owner]) begin
                    mode = 2;
                    exp_xl[owner] = 1'b1;
                end else if (idle_run >= TIMEOUT) begin
                    mode = 2;
                    exp_err = 1'b1;
                    exp_xl[owner] = 1'b1;
                end
            end
            default: begin
                if (exp_q.size() == 0) mode = 0;
            end
        endcase
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] g, input logic [N-1:0] v,
                         input logic [N-1:0] l, input logic sr);
        gnt     = g;
        m_valid = v;
        m_last  = l;
        s_ready = sr;
        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = $urandom;
    endtask

    task automatic run(input int cycles, input logic [N-1:0] g, input logic [N-1:0] v,
                       input logic [N-1:0] l, input logic sr);
        for (int c = 0; c < cycles; c++) begin
            drive(g, v, l, sr);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 4'b1111, 4'b0000, 1'b1);
        model_reset();
        @(negedge clk);

        // Reset held with all masters valid
        run(3, 4'b0000, 4'b1111, 4'b0000, 1'b1);
        rst = 1'b0;

        // Basic 4-beat transfer from master 2
        run(1, 4'b0100, 4'b0000, 4'b0000, 1'b1);
        run(3, 4'b0000, 4'b0100, 4'b0000, 1'b1);
        run(1, 4'b0000, 4'b0100, 4'b0100, 1'b1);
        run(5, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Backpressure on master 1
        run(1, 4'b0010, 4'b0000, 4'b0000, 1'b1);
        run(5, 4'b0000, 4'b0010, 4'b0000, 1'b0);
        run(2, 4'b0000, 4'b0010, 4'b0000, 1'b1);
        run(2, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        run(5, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Grant moves to master 3 mid-burst of master 0
        run(1, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        run(2, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        run(3, 4'b1000, 4'b1001, 4'b1000, 1'b1);
        run(1, 4'b1000, 4'b1001, 4'b1001, 1'b1);
        run(3, 4'b1000, 4'b1000, 4'b1000, 1'b1);
        run(4, 4'b0000, 4'b1000, 4'b1000, 1'b1);
        run(5, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Idle timeout on master 3
        run(1, 4'b1000, 4'b0000, 4'b0000, 1'b1);
        run(2, 4'b0000, 4'b1000, 4'b0000, 1'b1);
        run(TIMEOUT + 6, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Multi-hot grant is ignored
        run(3, 4'b0110, 4'b0110, 4'b0000, 1'b1);

        // Reset while two beats are buffered
        run(1, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        run(3, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        run(2, 4'b0000, 4'b0100, 4'b0100, 1'b1);
        rst = 1'b0;
        run(3, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] g;
            case ($urandom_range(0, 3))
                0:       g = '0;
                3:       g = N'($urandom_range(0, 15));
                default: g = N'(1) << $urandom_range(0, N-1);
            endcase
            drive(g, N'($urandom_range(0, 15)),
                  N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
            tick();
        end

        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
